rwt_up_bus_master: RTL
======================

Name: rwt_up_bus_master

Overview:
- Initiator for the team's up_* register bus. It converts a valid/ready command stream (single write or read) into one up_wreq/up_rreq transaction.
- Waits for up_wack/up_rack, then returns a response on a valid/ready stream.
- Guards against missing acks with a timeout, and counts timeouts as a status value.
- Sits between a control source (sequencer, debug UART bridge, init ROM) and any up_*-bus responder in the design.

Parameters:
- ADDR_WIDTH, 9, up bus address width.
- DATA_WIDTH, 32, up bus data width.
- TIMEOUT_CYCLES, 64, max cycles to wait for ack after request; must be ≥2.

Ports:
- up_clk  in  1  clock.
- up_rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and on error.
- rsp_error  out  1  timeout occurred.
- up_wreq  out  1  write request pulse.
- up_waddr  out  ADDR_WIDTH  write address.
- up_wdata  out  DATA_WIDTH  write data.
- up_wack  in  1  write acknowledge.
- up_rreq  out  1  read request pulse.
- up_raddr  out  ADDR_WIDTH  read address.
- up_rdata  in  DATA_WIDTH  read data, valid with up_rack.
- up_rack  in  1  read acknowledge.
- busy  out  1  high in any state except IDLE.
- timeout_count  out  16  saturating count of timed-out transactions.

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter and timeout_count cleared. Reset mid-transaction abandons it; no response is produced.
- States: IDLE, REQ, WAIT, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch write/addr/wdata, go to REQ.
  - up_waddr/up_wdata or up_raddr are driven from the latch in the next cycle.
- REQ:
  - Exactly one cycle; up_wreq=1 (write) or up_rreq=1 (read).
  - The request is a single-cycle pulse, because responders act on every cycle req is high.
  - Go to WAIT; timeout counter=1.
- WAIT:
  - req=0; address and data are held stable until RESP.
  - Ack of the matching type (wack for write, rack for read) → capture up_rdata (reads), rsp_error=0, go to RESP.
  - Otherwise, if counter==TIMEOUT_CYCLES → rsp_error=1, rsp_rdata=0, timeout_count+1 (saturates at 16'hFFFF), go to RESP.
  - Otherwise counter+1.
  - Ack and timeout in the same cycle: ack wins.
  - The wrong ack type, or an ack in the REQ cycle, is ignored (responders ack one cycle after req).
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready.
  - On handshake, rsp_valid drops next cycle and the state returns to IDLE.
  - cmd_ready rises in the cycle after the rsp handshake.
- Latency with a 1-cycle-ack responder:
  - cmd handshake at cycle N → req high at N+1 → ack at N+2 → rsp_valid at N+3.
  - Minimum command spacing is 4 cycles plus response backpressure.
- Stray acks in IDLE or RESP are ignored.
- cmd_* inputs are don't-care outside IDLE.

Decomposition:
- Shared package rwt_up_bus_pkg holds:
  - state enum (IDLE/REQ/WAIT/RESP);
  - UP_ADDR_WIDTH=9 and UP_DATA_WIDTH=32 constants;
  - UP_ERR_RDATA=0 constant.
- No sub-module is needed. The timeout counter and FSM live in one always block; the latch and response registers live in a second.

Test Plan:
- Write 0x002/0x12345678 with a 1-cycle-ack responder → up_wreq high exactly 1 cycle at N+1 with waddr=0x002 and wdata=0x12345678; rsp_valid at N+3 with rsp_write=1, rsp_error=0, rsp_rdata=0.
- Read 0x007 where the responder returns 0xABBABAAB → up_rreq 1-cycle pulse; rsp_rdata=0xABBABAAB, rsp_error=0.
- Read with the responder never acking, TIMEOUT_CYCLES=64 → rsp_valid 64 cycles after the WAIT entry; rsp_error=1, rsp_rdata=0, timeout_count=1.
- Ack arriving on exactly cycle 64 of WAIT → rsp_error=0 and the data is captured (ack wins).
- Hold rsp_ready=0 for 10 cycles with a second cmd pending → rsp_* stable, cmd_ready=0 throughout; second cmd accepted the cycle after the rsp handshake.
- Assert up_rstn low during WAIT → all outputs 0 immediately; no response afterward; a late ack is ignored; the next command completes normally.

Source files
------------

// File: rtl/rwt_up_bus_pkg.sv
// Shared definitions for the up_* bus master.
//   state_t       : bus master FSM states
//   UP_ADDR_WIDTH : default up bus address width
//   UP_DATA_WIDTH : default up bus data width
//   UP_ERR_RDATA  : read data returned with an errored (timed-out) response
package rwt_up_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int UP_ADDR_WIDTH = 9;
    localparam int UP_DATA_WIDTH = 32;

    localparam logic [UP_DATA_WIDTH-1:0] UP_ERR_RDATA = '0;

endpackage

// File: rtl/rwt_up_bus_master.sv
// Initiator for the up_* register bus.
// Accepts one command (write or read) on a valid/ready stream, issues a single
// cycle up_wreq/up_rreq, waits for the matching ack (bounded by TIMEOUT_CYCLES)
// and returns a response on a valid/ready stream.
//
// Ports:
//   up_clk, up_rstn        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command stream; cmd_write, cmd_addr, cmd_wdata
//   rsp_valid/rsp_ready    response stream; rsp_write, rsp_rdata, rsp_error
//   up_wreq/up_waddr/up_wdata/up_wack     up bus write channel
//   up_rreq/up_raddr/up_rdata/up_rack     up bus read channel
//   busy                   high whenever the FSM is not idle
//   timeout_count          saturating count of timed-out transactions
//
// Handshakes: a transfer happens on a rising up_clk edge where valid and ready
// are both high. A producer holds valid and its payload stable until that edge.
// All outputs are registered.
module rwt_up_bus_master
    import rwt_up_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = UP_ADDR_WIDTH,
    parameter int DATA_WIDTH     = UP_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  up_clk,
    input  logic                  up_rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  up_wreq,
    output logic [ADDR_WIDTH-1:0] up_waddr,
    output logic [DATA_WIDTH-1:0] up_wdata,
    input  logic                  up_wack,
    output logic                  up_rreq,
    output logic [ADDR_WIDTH-1:0] up_raddr,
    input  logic [DATA_WIDTH-1:0] up_rdata,
    input  logic                  up_rack,
    output logic                  busy,
    output logic [15:0]           timeout_count
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic            wr_q;
    logic            cmd_fire;
    logic            rsp_fire;
    logic            ack;
    logic            timed_out;

    // cmd_ready is only ever high in IDLE, so cmd_fire implies IDLE.
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign rsp_fire  = rsp_valid & rsp_ready;
    // Only the ack matching the outstanding request counts.
    assign ack       = wr_q ? up_wack : up_rack;
    assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_fire)          state_next = ST_REQ;
            ST_REQ:                         state_next = ST_WAIT;
            ST_WAIT: if (ack || timed_out)  state_next = ST_RESP;
            ST_RESP: if (rsp_fire)          state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    // FSM state, timeout counter and the status/strobe outputs.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            timeout_count <= '0;
            cmd_ready     <= 1'b0;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            up_wreq       <= 1'b0;
            up_rreq       <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == ST_IDLE);
            busy      <= (state_next != ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
            // Requests are one-cycle pulses: cmd_ready drops in the REQ cycle,
            // so cmd_fire cannot repeat on the following edge.
            up_wreq   <= cmd_fire & cmd_write;
            up_rreq   <= cmd_fire & ~cmd_write;

            if (state == ST_REQ) begin
                wait_cnt <= CW'(1);
            end else if (state == ST_WAIT && !ack && !timed_out) begin
                wait_cnt <= wait_cnt + CW'(1);
            end

            if (state == ST_WAIT && !ack && timed_out && timeout_count != 16'hFFFF) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end

    // Command latch (drives the bus address/data) and response registers.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wr_q      <= 1'b0;
            up_waddr  <= '0;
            up_wdata  <= '0;
            up_raddr  <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            if (cmd_fire) begin
                wr_q <= cmd_write;
                if (cmd_write) begin
                    up_waddr <= cmd_addr;
                    up_wdata <= cmd_wdata;
                end else begin
                    up_raddr <= cmd_addr;
                end
            end

            // Ack beats timeout when both land in the same cycle.
            if (state == ST_WAIT && (ack || timed_out)) begin
                rsp_write <= wr_q;
                rsp_error <= ~ack;
                rsp_rdata <= (ack && !wr_q) ? up_rdata : DATA_WIDTH'(UP_ERR_RDATA);
            end
        end
    end

endmodule
